// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: buffers unsigned ADC samples in a small FIFO and feeds them
// one at a time to a FIR. Offset-binary samples are converted to two's
// complement on the way in, and results are converted back on the way out.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_data      upstream sample; in_ready = FIFO not full
//   fir_start/fir_x       one-cycle start pulse and signed sample to the FIR
//   fir_done/fir_y        FIR result-valid pulse and signed result
//   out_valid/out_data    converted result, held until out_ready
//   overrun, timeout      sticky error flags, cleared by clear_flags
//   busy                  FSM active or FIFO holding samples
module fir_sample_feeder #(
  parameter int unsigned DataWidth     = 12,
  parameter int unsigned FifoDepth     = 4,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [DataWidth-1:0] in_data,
  output logic                 in_ready,
  output logic                 fir_start,
  output logic [DataWidth-1:0] fir_x,
  input  logic                 fir_done,
  input  logic [DataWidth-1:0] fir_y,
  output logic                 out_valid,
  output logic [DataWidth-1:0] out_data,
  input  logic                 out_ready,
  output logic                 overrun,
  output logic                 timeout,
  input  logic                 clear_flags,
  output logic                 busy
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
  localparam logic [DataWidth-1:0] SignFlip = {1'b1, {(DataWidth-1){1'b0}}};
  // WAIT cycle k after fir_start sees cnt = k-1; expiring on this value makes
  // the timeout flag visible exactly TimeoutCycles cycles after fir_start.
  localparam logic [CntW-1:0] LastCnt = CntW'(TimeoutCycles - 2);

  typedef enum logic [1:0] {IDLE, START, WAIT, OUT} state_t;

  state_t                 state, state_next;
  logic [DataWidth-1:0]   mem [FifoDepth];
  logic [PtrW-1:0]        wr_ptr, rd_ptr;
  logic [PtrW:0]          count;
  logic [CntW-1:0]        cnt;
  logic                   full, empty, push, pop;
  logic                   done_hit, timeout_hit;

  assign full      = (count == (PtrW+1)'(FifoDepth));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign push      = in_valid & ~full;
  assign fir_start = (state == START);
  assign out_valid = (state == OUT);
  assign busy      = (state != IDLE) | ~empty;

  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    done_hit    = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: state_next = WAIT;
      WAIT: begin
        if (fir_done) begin
          done_hit   = 1'b1;
          state_next = OUT;
        end else if (cnt == LastCnt) begin
          timeout_hit = 1'b1;
          state_next  = IDLE;
        end
      end
      OUT: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Storage array carries no reset; occupancy is governed by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      cnt      <= '0;
      fir_x    <= '0;
      out_data <= '0;
      overrun  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state <= state_next;

      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      if (push && !pop)      count <= count + (PtrW+1)'(1);
      else if (pop && !push) count <= count - (PtrW+1)'(1);

      if (pop) fir_x <= mem[rd_ptr] ^ SignFlip;

      if (state == START)     cnt <= '0;
      else if (state == WAIT) cnt <= cnt + CntW'(1);

      if (done_hit) out_data <= fir_y ^ SignFlip;

      if (clear_flags)             overrun <= 1'b0;
      else if (in_valid && full)   overrun <= 1'b1;

      if (clear_flags)      timeout <= 1'b0;
      else if (timeout_hit) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fir_sample_feeder.sv
module tb_fir_sample_feeder;

  localparam int W = 12;
  localparam int T = 255;
  localparam logic [W-1:0] MSBV = {1'b1, {(W-1){1'b0}}};

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         fir_start;
  logic [W-1:0] fir_x;
  logic         fir_done;
  logic [W-1:0] fir_y;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         overrun;
  logic         timeout;
  logic         clear_flags;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic sb_en = 1'b0;
  logic [W-1:0] sample_q[$];
  logic [W-1:0] result_q[$];

  fir_sample_feeder #(
    .DataWidth(W),
    .FifoDepth(4),
    .TimeoutCycles(T)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_ready(in_ready),
    .fir_start(fir_start),
    .fir_x(fir_x),
    .fir_done(fir_done),
    .fir_y(fir_y),
    .out_valid(out_valid),
    .out_data(out_data),
    .out_ready(out_ready),
    .overrun(overrun),
    .timeout(timeout),
    .clear_flags(clear_flags),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic checkw(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT presents output.
  task automatic monitor_loop();
    logic         hold_prev;
    logic [W-1:0] hold_data;
    logic [W-1:0] e;
    hold_prev = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        if (fir_start) begin
          if (sample_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_fir_x: got start with fir_x %h expected no start", fir_x);
          end else begin
            e = sample_q.pop_front();
            checkw("sb_fir_x", fir_x, e);
          end
        end
        if (hold_prev) begin
          check1("sb_hold_valid", out_valid, 1'b1);
          checkw("sb_hold_data", out_data, hold_data);
        end
        if (out_valid && out_ready) begin
          if (result_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_out_data: got output %h expected no output", out_data);
          end else begin
            e = result_q.pop_front();
            checkw("sb_out_data", out_data, e);
          end
        end
        hold_prev = out_valid && !out_ready;
        hold_data = out_data;
      end else begin
        hold_prev = 1'b0;
      end
    end
  endtask

  task automatic wait_start(input string name);
    int n;
    n = 0;
    while (!fir_start && n < 20) begin
      tick();
      n++;
    end
    check1(name, fir_start, 1'b1);
  endtask

  task automatic one_txn(input logic [W-1:0] s, input logic [W-1:0] y);
    in_valid = 1'b1;
    in_data  = s;
    tick();
    in_valid = 1'b0;
    wait_start("txn_start");
    checkw("txn_fir_x", fir_x, s ^ MSBV);
    tick();
    fir_done = 1'b1;
    fir_y    = y;
    tick();
    fir_done = 1'b0;
    check1("txn_out_valid", out_valid, 1'b1);
    checkw("txn_out_data", out_data, y ^ MSBV);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1("txn_out_done", out_valid, 1'b0);
  endtask

  initial begin
    logic [W-1:0] vals [5];
    int           s_cyc;
    logic         pending;
    int unsigned  dly;
    logic         ov_exp;
    logic         gen;

    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; fir_done = 1'b0; fir_y = '0;
    out_ready = 1'b0; clear_flags = 1'b0;
    fork
      monitor_loop();
    join_none

    // Reset values
    repeat (3) tick();
    check1("rst_fir_start", fir_start, 1'b0);
    checkw("rst_fir_x", fir_x, '0);
    check1("rst_out_valid", out_valid, 1'b0);
    checkw("rst_out_data", out_data, '0);
    check1("rst_overrun", overrun, 1'b0);
    check1("rst_timeout", timeout, 1'b0);
    rst_n = 1'b1;
    tick();
    check1("rst_in_ready", in_ready, 1'b1);
    check1("rst_busy", busy, 1'b0);

    // Latency and conversion: 0x800 -> fir_x 0x000, fir_y 0x7FF -> 0xFFF
    in_valid = 1'b1;
    in_data  = 12'h800;
    tick();
    in_valid = 1'b0;
    check1("lat_no_start_n1", fir_start, 1'b0);
    check1("lat_busy", busy, 1'b1);
    tick();
    check1("lat_start_n2", fir_start, 1'b1);
    checkw("lat_fir_x", fir_x, 12'h000);
    tick();
    check1("start_one_cycle", fir_start, 1'b0);
    checkw("fir_x_held", fir_x, 12'h000);
    fir_done = 1'b1;
    fir_y    = 12'h7FF;
    tick();
    fir_done = 1'b0;
    check1("out_valid_after_done", out_valid, 1'b1);
    checkw("out_data_7ff", out_data, 12'hFFF);

    // Back-pressure in OUT for 10 cycles with another sample queued
    in_valid = 1'b1;
    in_data  = 12'h123;
    for (int i = 0; i < 10; i++) begin
      tick();
      in_valid = 1'b0;
      check1("bp_out_valid", out_valid, 1'b1);
      checkw("bp_out_data", out_data, 12'hFFF);
      check1("bp_no_start", fir_start, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check1("bp_released", out_valid, 1'b0);
    check1("bp_start_h1", fir_start, 1'b0);
    tick();
    check1("bp_start_h2", fir_start, 1'b1);
    checkw("bp_fir_x", fir_x, 12'h123 ^ MSBV);
    // fir_done during START must be ignored
    fir_done = 1'b1;
    fir_y    = 12'h800;
    tick();
    check1("done_in_start_ignored", out_valid, 1'b0);
    tick();
    fir_done = 1'b0;
    check1("out_valid_800", out_valid, 1'b1);
    checkw("out_data_800", out_data, 12'h000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    one_txn(12'h000, 12'h000);
    one_txn(12'h7FF, 12'h3C5);

    // Overrun with the FIR stalled, then timeout
    vals[0] = 12'h0AB; vals[1] = 12'hF00; vals[2] = 12'h555;
    vals[3] = 12'h7FF; vals[4] = 12'h321;
    in_valid = 1'b1;
    in_data  = 12'h100;
    tick();
    in_valid = 1'b0;
    wait_start("ovr_first_start");
    s_cyc = cyc;
    for (int i = 0; i < 5; i++) begin
      check1("ovr_in_ready", in_ready, i < 4);
      check1("ovr_not_yet", overrun, 1'b0);
      in_valid = 1'b1;
      in_data  = vals[i];
      tick();
    end
    in_valid = 1'b0;
    check1("ovr_set", overrun, 1'b1);
    check1("ovr_full", in_ready, 1'b0);
    in_valid    = 1'b1;
    clear_flags = 1'b1;
    tick();
    in_valid    = 1'b0;
    clear_flags = 1'b0;
    check1("ovr_clear_wins", overrun, 1'b0);
    tick();
    check1("ovr_stays_clear", overrun, 1'b0);

    while (cyc < s_cyc + T - 1) tick();
    check1("timeout_not_early", timeout, 1'b0);
    tick();
    check1("timeout_exact", timeout, 1'b1);
    check1("timeout_no_output", out_valid, 1'b0);
    tick();
    check1("timeout_next_start", fir_start, 1'b1);
    checkw("timeout_next_fir_x", fir_x, vals[0] ^ MSBV);
    clear_flags = 1'b1;
    tick();
    clear_flags = 1'b0;
    check1("timeout_cleared", timeout, 1'b0);

    // Asynchronous reset in WAIT with three samples still queued
    rst_n = 1'b0;
    #1;
    check1("mid_rst_fir_start", fir_start, 1'b0);
    checkw("mid_rst_fir_x", fir_x, '0);
    check1("mid_rst_out_valid", out_valid, 1'b0);
    checkw("mid_rst_out_data", out_data, '0);
    check1("mid_rst_overrun", overrun, 1'b0);
    check1("mid_rst_timeout", timeout, 1'b0);
    check1("mid_rst_busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check1("post_rst_no_start", fir_start, 1'b0);
      check1("post_rst_no_out", out_valid, 1'b0);
    end
    check1("post_rst_in_ready", in_ready, 1'b1);
    check1("post_rst_busy", busy, 1'b0);

    // Randomized traffic against the scoreboard
    sb_en   = 1'b1;
    pending = 1'b0;
    dly     = 0;
    ov_exp  = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      check1("rand_overrun", overrun, ov_exp);
      if (clear_flags)                ov_exp = 1'b0;
      else if (in_valid && !in_ready) ov_exp = 1'b1;
      if (in_valid && in_ready) sample_q.push_back(in_data ^ MSBV);
      if (fir_start) begin
        pending = 1'b1;
        dly     = $urandom_range(1, 6);
      end
      tick();
      gen         = (k < 2500);
      in_valid    = gen && ($urandom_range(0, 9) < 4);
      in_data     = W'($urandom);
      out_ready   = ($urandom_range(0, 3) != 0);
      clear_flags = ($urandom_range(0, 15) == 0);
      fir_done    = 1'b0;
      if (pending) begin
        dly--;
        if (dly == 0) begin
          fir_done = 1'b1;
          fir_y    = W'($urandom);
          result_q.push_back(fir_y ^ MSBV);
          pending  = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        fir_done = 1'b1;
        fir_y    = W'($urandom);
      end
    end
    sb_en = 1'b0;
    checkw("drain_samples", W'(sample_q.size()), '0);
    checkw("drain_results", W'(result_q.size()), '0);
    check1("drain_pending", pending, 1'b0);
    check1("drain_busy", busy, 1'b0);
    check1("rand_no_timeout", timeout, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_sample_feeder.md
FIR_SAMPLE_FEEDER -- requirements
Module: fir_sample_feeder

Interface
REQ-001 Parameter DataWidth, default 12: width of every sample bus.
REQ-002 Parameter FifoDepth, default 4 (power of two, >=2): input FIFO entries.
REQ-003 Parameter TimeoutCycles, default 255: maximum cycles allowed from fir_start to fir_done.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 Port in_valid, input, 1: upstream (ADC) sample valid.
REQ-007 Port in_data, input, DataWidth: unsigned ADC sample.
REQ-008 Port in_ready, output, 1: FIFO can accept a sample.
REQ-009 Port fir_start, output, 1: one-cycle start pulse to the FIR.
REQ-010 Port fir_x, output, DataWidth: signed sample presented to the FIR.
REQ-011 Port fir_done, input, 1: FIR result-valid pulse.
REQ-012 Port fir_y, input, DataWidth: signed FIR result.
REQ-013 Port out_valid, output, 1: converted result valid.
REQ-014 Port out_data, output, DataWidth: unsigned result.
REQ-015 Port out_ready, input, 1: downstream accepts out_data.
REQ-016 Port overrun, output, 1: sticky flag, sample dropped on full FIFO.
REQ-017 Port timeout, output, 1: sticky flag, fir_done missing.
REQ-018 Port clear_flags, input, 1: synchronous clear of overrun and timeout.
REQ-019 Port busy, output, 1: FSM not in IDLE, or FIFO not empty.

Function
REQ-020 Push occurs when in_valid && in_ready; in_ready = FIFO not full.
REQ-021 in_valid while FIFO full: sample dropped, FIFO unchanged, overrun set next cycle.
REQ-022 Push and pop in the same cycle: occupancy unchanged; data order preserved (FIFO, pointers wrap modulo FifoDepth).
REQ-023 Conversion in: fir_x = head sample with MSB inverted (offset binary to two's complement).
REQ-024 Conversion out: out_data = fir_y with MSB inverted.
REQ-025 FSM states: IDLE, START, WAIT, OUT.
REQ-026 IDLE: if FIFO not empty, pop head, register converted value into fir_x, go to START; else stay.
REQ-027 START: fir_start=1 for exactly this cycle; go to WAIT; timeout counter cleared.
REQ-028 WAIT: fir_x held stable; on fir_done register converted fir_y into out_data, go to OUT.
REQ-029 WAIT: counter increments each cycle; on reaching TimeoutCycles without fir_done, set timeout, go to IDLE, no output produced.
REQ-030 OUT: out_valid=1 and out_data stable until out_ready; on out_valid && out_ready go to IDLE.
REQ-031 fir_done outside WAIT is ignored.
REQ-032 Latency: sample pushed into empty FIFO while IDLE at edge N -> fir_start high in cycle N+2; out_valid high the cycle after fir_done.
REQ-033 At most one sample in flight in the FIR; FIFO continues accepting during WAIT/OUT.
REQ-034 clear_flags has priority over a same-cycle set event (clear wins).

Reset
REQ-035 rst_n low: immediately FSM=IDLE, FIFO empty, counter=0, fir_start=0, fir_x=0, out_valid=0, out_data=0, overrun=0, timeout=0; in_ready=1, busy=0 after deassertion.
REQ-036 Reset asserted mid-operation (any state) discards the FIFO contents and the in-flight sample; no out_valid after release until a new sample completes.

Verification
REQ-037 Push in_data=0x800 while idle -> fir_x=0x000, one-cycle fir_start two cycles later; drive fir_y=0x7FF with fir_done -> out_valid, out_data=0xFFF.
REQ-038 fir_y=0x800 -> out_data=0x000; fir_y=0x000 -> out_data=0x800.
REQ-039 Hold fir_done low, push 5 samples with FifoDepth=4 -> in_ready low after 4 pushes, 5th dropped, overrun=1; clear_flags -> overrun=0.
REQ-040 Never assert fir_done -> timeout=1 exactly TimeoutCycles cycles after fir_start, FSM back to IDLE, next queued sample started.
REQ-041 Hold out_ready low 10 cycles in OUT -> out_valid and out_data stable, no new fir_start; release -> next fir_start two cycles after handshake.
REQ-042 Assert rst_n low during WAIT with 3 samples queued -> all outputs at reset values, no later out_valid without new input.
